// File: rtl/apb_uart_tx_feeder_if.sv
// Byte stream in, APB master out: the bundle between the TX feeder and its
// neighbours. master = feeder side, slave = producer/UART side.
interface apb_uart_tx_feeder_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  in_valid, in_data, PRDATA, PREADY,
        output in_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output in_valid, in_data, PRDATA, PREADY,
        input  in_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_uart_tx_feeder.sv
// Byte FIFO that drains into an APB UART: polls STAT until the TX side has
// room, then writes the FIFO head to the TX data register.
// Ports: clk, rst (sync, active high), bus (master modport: in_valid/
// in_data/in_ready stream + APB PSEL..PREADY), fifo_count, busy.
// Macro TX_FEEDER_INIT_EN: after reset, write BAUDDIV_VAL then CTRL_VAL
// to the UART before serving the FIFO.
module apb_uart_tx_feeder #(
    parameter int          DEPTH       = 8,
    parameter logic [19:0] BAUDDIV_VAL = 20'd16,
    parameter logic [31:0] CTRL_VAL    = 32'h0000_0001
) (
    input  logic                     clk,
    input  logic                     rst,
    apb_uart_tx_feeder_if.master     bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [9:0] ADDR_TX   = 10'h000;
    localparam logic [9:0] ADDR_STAT = 10'h001;

    typedef enum logic [3:0] {
        IDLE,
        POLL_S,
        POLL_A,
        WR_S,
        WR_A
`ifdef TX_FEEDER_INIT_EN
        ,
        INIT_BAUD_S,
        INIT_BAUD_A,
        INIT_CTRL_S,
        INIT_CTRL_A
`endif
    } state_t;

`ifdef TX_FEEDER_INIT_EN
    localparam logic [9:0] ADDR_CTRL = 10'h002;
    localparam logic [9:0] ADDR_BAUD = 10'h004;
    localparam state_t     RST_ST    = INIT_BAUD_S;
`else
    localparam state_t     RST_ST    = IDLE;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [9:0]    paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          push, pop;

    assign bus.in_ready = (count_q != CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_count   = count_q;
    assign busy         = (state_q != IDLE) || (count_q != '0);

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE:   if (count_q != '0) state_d = POLL_S;
            POLL_S: state_d = POLL_A;
            POLL_A: if (bus.PREADY) state_d = bus.PRDATA[0] ? POLL_S : WR_S;
            WR_S:   state_d = WR_A;
            WR_A: begin
                if (bus.PREADY) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef TX_FEEDER_INIT_EN
            // Outputs are still zero the cycle after reset, so the setup
            // phase must be on the bus before moving to access.
            INIT_BAUD_S: if (psel_q) state_d = INIT_BAUD_A;
            INIT_BAUD_A: if (bus.PREADY) state_d = INIT_CTRL_S;
            INIT_CTRL_S: state_d = INIT_CTRL_A;
            INIT_CTRL_A: if (bus.PREADY) state_d = IDLE;
`endif
            default: state_d = RST_ST;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    // APB outputs are decoded from the next state so they leave the flops
    // aligned with the state they belong to.
    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
        unique case (state_d)
            POLL_S: begin
                psel_d  = 1'b1;
                paddr_d = ADDR_STAT;
            end
            POLL_A: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                paddr_d   = ADDR_STAT;
            end
            WR_S: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = ADDR_TX;
                pwdata_d = {24'h0, mem_q[rd_ptr_q]};
            end
            WR_A: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                pwrite_d  = 1'b1;
                paddr_d   = ADDR_TX;
                pwdata_d  = pwdata_q;
            end
`ifdef TX_FEEDER_INIT_EN
            INIT_BAUD_S, INIT_BAUD_A: begin
                psel_d    = 1'b1;
                penable_d = (state_d == INIT_BAUD_A);
                pwrite_d  = 1'b1;
                paddr_d   = ADDR_BAUD;
                pwdata_d  = {12'h0, BAUDDIV_VAL};
            end
            INIT_CTRL_S, INIT_CTRL_A: begin
                psel_d    = 1'b1;
                penable_d = (state_d == INIT_CTRL_A);
                pwrite_d  = 1'b1;
                paddr_d   = ADDR_CTRL;
                pwdata_d  = CTRL_VAL;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_ST;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= bus.in_data;
    end
endmodule
